// File: rtl/fft_out_unloader.sv
// Receives 4-lane FFT output beats into a ping-pong frame buffer and replays each
// frame as a 1-bin-per-cycle valid/ready stream, in capture or bit-reversed order.
module fft_out_unloader #(
    parameter int NBITS_out = 19,
    parameter int N         = 128,
    parameter int LOGN      = 7,
    parameter bit BITREV    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NBITS_out-1:0] fftOut0_up,
    input  logic [2*NBITS_out-1:0] fftOut0_down,
    input  logic [2*NBITS_out-1:0] fftOut1_up,
    input  logic [2*NBITS_out-1:0] fftOut1_down,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic [2*NBITS_out-1:0] m_data,
    output logic [LOGN-1:0]        m_index,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   sync_err,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);
    localparam int W  = 2*NBITS_out;
    localparam int BW = LOGN-2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N/4 - 1);

    typedef enum logic [1:0] {WAIT_SOF, FILL, DROP} wrState_t;

    function automatic logic [LOGN-1:0] bitRev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
        return r;
    endfunction

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    wrState_t      wrState;
    logic          wrBank, rdBank, frBank;
    logic [1:0]    full, setMask, freeMask;
    logic [BW-1:0] beatCnt, wrBeat;
    logic          wrEn;

    // One RAM per lane; address is {bank, beat}, so bin a lives in lane a[1:0] at beat a>>2
    logic [W-1:0]  ram [4][N/2];

    logic [LOGN-1:0] rdCnt, rdAddr;
    logic            issue, accept, loadSkid;
    logic [1:0]      occ;

    logic            vld_p1;
    logic [W-1:0]    data_p1;
    logic [LOGN-1:0] idx_p1;
    logic            last_p1;

    logic            skidVld;
    logic [W-1:0]    skidData;
    logic [LOGN-1:0] skidIdx;
    logic            skidLast;

    always_comb begin
        wrEn    = 1'b0;
        wrBeat  = beatCnt;
        setMask = 2'b00;
        case (wrState)
            WAIT_SOF: if (in_valid && in_sof && !full[wrBank]) begin
                wrEn   = 1'b1;
                wrBeat = '0;
            end
            FILL: if (in_valid) begin
                wrEn = 1'b1;
                if (in_sof)                    wrBeat  = '0;
                else if (beatCnt == LAST_BEAT) setMask = wrBank ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrState  <= WAIT_SOF;
            wrBank   <= 1'b0;
            beatCnt  <= '0;
            sync_err <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            sync_err <= 1'b0;
            case (wrState)
                WAIT_SOF: if (in_valid && in_sof) begin
                    beatCnt <= BW'(1);
                    if (full[wrBank]) begin
                        wrState  <= DROP;
                        overflow <= 1'b1;
                        drop_cnt <= satInc(drop_cnt);
                    end else begin
                        wrState <= FILL;
                    end
                end
                FILL: if (in_valid) begin
                    if (in_sof) begin
                        sync_err <= 1'b1;
                        beatCnt  <= BW'(1);
                    end else if (beatCnt == LAST_BEAT) begin
                        beatCnt <= '0;
                        wrBank  <= ~wrBank;
                        wrState <= WAIT_SOF;
                    end else begin
                        beatCnt <= beatCnt + 1'b1;
                    end
                end
                DROP: if (in_valid) begin
                    if (in_sof) begin
                        beatCnt <= BW'(1);
                    end else if (beatCnt == LAST_BEAT) begin
                        beatCnt <= '0;
                        wrState <= WAIT_SOF;
                    end else begin
                        beatCnt <= beatCnt + 1'b1;
                    end
                end
                default: wrState <= WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            ram[0][{wrBank, wrBeat}] <= fftOut0_up;
            ram[1][{wrBank, wrBeat}] <= fftOut0_down;
            ram[2][{wrBank, wrBeat}] <= fftOut1_up;
            ram[3][{wrBank, wrBeat}] <= fftOut1_down;
        end
    end

    // A bank is released only when its last bin is handed over downstream
    always_comb begin
        freeMask = (m_valid && m_ready && m_last) ? (frBank ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) full <= 2'b00;
        else      full <= (full | setMask) & ~freeMask;
    end

    // Issue a read only if out + skid can absorb it even if the sink stalls next cycle
    always_comb begin
        accept   = m_valid & m_ready;
        occ      = 2'(m_valid) + 2'(skidVld) + 2'(vld_p1) - 2'(accept);
        issue    = full[rdBank] && (occ <= 2'd1);
        rdAddr   = BITREV ? bitRev(rdCnt) : rdCnt;
        loadSkid = vld_p1 && (skidVld || (m_valid && !m_ready));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdBank <= 1'b0;
            rdCnt  <= '0;
            frBank <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                rdCnt <= rdCnt + 1'b1;
                if (&rdCnt) rdBank <= ~rdBank;
            end
            if (accept && m_last) frBank <= ~frBank;
        end
    end

    // p1: registered RAM read
    always_ff @(posedge clk) begin
        if (issue) begin
            data_p1 <= ram[rdAddr[1:0]][{rdBank, rdAddr[LOGN-1:2]}];
            idx_p1  <= rdCnt;
            last_p1 <= &rdCnt;
        end
    end

    // Output register fed from the skid entry first so order is preserved
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
            m_last  <= 1'b0;
            skidVld <= 1'b0;
        end else begin
            if (!m_valid || accept) begin
                if (skidVld) begin
                    m_valid <= 1'b1;
                    m_data  <= skidData;
                    m_index <= skidIdx;
                    m_last  <= skidLast;
                end else begin
                    m_valid <= vld_p1;
                    if (vld_p1) begin
                        m_data  <= data_p1;
                        m_index <= idx_p1;
                        m_last  <= last_p1;
                    end
                end
            end
            if (loadSkid)                skidVld <= 1'b1;
            else if (!m_valid || accept) skidVld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (loadSkid) begin
            skidData <= data_p1;
            skidIdx  <= idx_p1;
            skidLast <= last_p1;
        end
    end
endmodule

// File: tb/tb_fft_out_unloader.sv
// Scoreboard bench for fft_out_unloader: capture-order and bit-reversed instances
// share stimulus; a negedge monitor pops expected bins on every handshake.
module tb_fft_out_unloader;
    localparam int NB   = 19;
    localparam int N    = 128;
    localparam int LOGN = 7;
    localparam int W    = 2*NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] l0, l1, l2, l3;
    logic in_valid = 1'b0, in_sof = 1'b0, m_ready = 1'b1;

    logic [W-1:0]    d0_data, d1_data;
    logic [LOGN-1:0] d0_index, d1_index;
    logic            d0_valid, d1_valid, d0_last, d1_last;
    logic            d0_sync, d1_sync, d0_ovf, d1_ovf;
    logic [7:0]      d0_drop, d1_drop;

    fft_out_unloader #(.NBITS_out(NB), .N(N), .LOGN(LOGN), .BITREV(1'b0)) dut (
        .clk(clk), .rst(rst),
        .fftOut0_up(l0), .fftOut0_down(l1), .fftOut1_up(l2), .fftOut1_down(l3),
        .in_valid(in_valid), .in_sof(in_sof),
        .m_data(d0_data), .m_index(d0_index), .m_valid(d0_valid), .m_last(d0_last),
        .m_ready(m_ready), .sync_err(d0_sync), .overflow(d0_ovf), .drop_cnt(d0_drop)
    );

    fft_out_unloader #(.NBITS_out(NB), .N(N), .LOGN(LOGN), .BITREV(1'b1)) dutRev (
        .clk(clk), .rst(rst),
        .fftOut0_up(l0), .fftOut0_down(l1), .fftOut1_up(l2), .fftOut1_down(l3),
        .in_valid(in_valid), .in_sof(in_sof),
        .m_data(d1_data), .m_index(d1_index), .m_valid(d1_valid), .m_last(d1_last),
        .m_ready(m_ready), .sync_err(d1_sync), .overflow(d1_ovf), .drop_cnt(d1_drop)
    );

    typedef struct packed {
        logic [W-1:0]    d;
        logic [LOGN-1:0] i;
        logic            l;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nCmp = 0;
    int   nErr = 0;
    int   cyc = 0;
    int   popCnt[2] = '{0, 0};
    bit   stall[2] = '{1'b0, 1'b0};
    exp_t held[2];
    int   se[2] = '{0, 0};
    int   readyMode = 0;
    int   firstV = -1;
    int   lastBeatCyc = 0;
    bit   armLat = 1'b0;
    int   s0, s1, n;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] word(input int tag, input int a);
        logic [NB-1:0] re;
        re = NB'(tag*256 + a);
        return {re, ~re};
    endfunction

    function automatic logic [LOGN-1:0] rev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkIdle(input string name);
        chk({name, "_dut0"}, 64'({d0_valid, d0_data, d0_index, d0_last, d0_sync, d0_ovf, d0_drop}), 64'd0);
        chk({name, "_dut1"}, 64'({d1_valid, d1_data, d1_index, d1_last, d1_sync, d1_ovf, d1_drop}), 64'd0);
    endtask

    task automatic monCheck(input int u, input logic v, input logic r, input logic [W-1:0] d,
                            input logic [LOGN-1:0] i, input logic l);
        exp_t got, e;
        got = {d, i, l};
        if (stall[u]) begin
            nCmp++;
            if (!v || got !== held[u]) begin
                nErr++;
                $display("FAIL hold_dut%0d: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d",
                         u, v, d, i, held[u].d, held[u].i);
            end
        end
        if (v && r) begin
            nCmp++;
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                nErr++;
                $display("FAIL extra_out_dut%0d: got idx %0d expected no output", u, i);
            end else begin
                if (u == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (got !== e) begin
                    nErr++;
                    $display("FAIL bin_dut%0d: got d=%0h i=%0d l=%0b expected d=%0h i=%0d l=%0b",
                             u, d, i, l, e.d, e.i, e.l);
                end
                popCnt[u]++;
            end
        end
        stall[u] = v && !r;
        held[u]  = got;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            monCheck(0, d0_valid, m_ready, d0_data, d0_index, d0_last);
            monCheck(1, d1_valid, m_ready, d1_data, d1_index, d1_last);
            if (d0_sync) se[0]++;
            if (d1_sync) se[1]++;
            if (armLat && d0_valid && firstV < 0) firstV = cyc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                2: m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic sendFrame(input int tag, input int beats, input bit gaps, input bit push);
        int g;
        if (push) begin
            for (int i = 0; i < N; i++) begin
                q0.push_back({word(tag, i), LOGN'(i), i == N-1});
                q1.push_back({word(tag, int'(rev(LOGN'(i)))), LOGN'(i), i == N-1});
            end
        end
        for (int k = 0; k < beats; k++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    in_valid = 1'b0;
                    in_sof   = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_sof   = (k == 0);
            l0 = word(tag, 4*k);
            l1 = word(tag, 4*k+1);
            l2 = word(tag, 4*k+2);
            l3 = word(tag, 4*k+3);
            lastBeatCyc = cyc + 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        nCmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nErr++;
            $display("FAIL %s_drain: got %0d/%0d bins left expected 0", name, q0.size(), q1.size());
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        l0 = '0; l1 = '0; l2 = '0; l3 = '0;
        #3 rst = 1'b0;
        #1 chkIdle("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // ramp frame, full-rate sink, latency bound
        readyMode = 0;
        firstV = -1;
        armLat = 1'b1;
        sendFrame(0, 32, 1'b0, 1'b1);
        waitDrain("ramp", 400);
        armLat = 1'b0;
        chk("ramp_latency", 64'(firstV >= 0 && (firstV - lastBeatCyc) <= 3), 64'd1);
        chk("ramp_no_ovf", 64'(d0_ovf), 64'd0);

        // alternating and random back-pressure, random input gaps
        readyMode = 2;
        sendFrame(5, 32, 1'b0, 1'b1);
        waitDrain("alt_ready", 800);
        readyMode = 3;
        sendFrame(6, 32, 1'b1, 1'b1);
        waitDrain("rand_ready", 1500);

        // three frames with a stalled sink: third is dropped
        readyMode = 1;
        sendFrame(1, 32, 1'b0, 1'b1);
        sendFrame(2, 32, 1'b0, 1'b1);
        sendFrame(3, 32, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_ovf0", 64'(d0_ovf), 64'd1);
        chk("drop_cnt0", 64'(d0_drop), 64'd1);
        chk("drop_ovf1", 64'(d1_ovf), 64'd1);
        chk("drop_cnt1", 64'(d1_drop), 64'd1);
        chk("drop_valid_held", 64'(d0_valid), 64'd1);
        readyMode = 0;
        waitDrain("drop", 800);

        // sof re-asserted at beat 10
        s0 = se[0];
        s1 = se[1];
        sendFrame(9, 10, 1'b0, 1'b0);
        sendFrame(10, 32, 1'b0, 1'b1);
        waitDrain("resync", 400);
        chk("resync_pulse0", 64'(se[0] - s0), 64'd1);
        chk("resync_pulse1", 64'(se[1] - s1), 64'd1);
        chk("resync_drop_cnt", 64'(d0_drop), 64'd1);

        // reset in the middle of output
        popCnt[0] = 0;
        sendFrame(7, 32, 1'b0, 1'b1);
        n = 0;
        while (popCnt[0] < 50 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_reached", 64'(popCnt[0] == 50), 64'd1);
        #2 rst = 1'b0;
        #1 chkIdle("midreset");
        q0.delete();
        q1.delete();
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        sendFrame(8, 32, 1'b0, 1'b1);
        waitDrain("after_reset", 400);
        chk("after_reset_ovf", 64'(d0_ovf), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
